hazard_ctrl: RTL and testbench

- Central hazard scheduler for the 5-stage MIPS pipeline (F/D/E/M/W).
- Consumes D-stage decode fields (source registers, Tuse, destination register, Tnew, mult/div class). Keeps its own shadow pipeline of destination/Tnew for E, M and W.
- Produces the D-stage stall, all forwarding-mux selects, and the busy window of the multi-cycle multiply/divide unit.

---
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - MIPS 5-stage hazard scheduler: D stall, forwarding selects, MD busy window
// Optional feature macro: HAZARD_STALL_STATS_EN (adds stall_cnt, a wrapping count of stalled cycles)
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic [4:0]  d_a3,
  input  logic [1:0]  d_tnew,
  input  logic        d_md_start,
  input  logic        d_md_div,
  input  logic        d_md_use,
  output logic        stall,
  output logic [1:0]  fwd_d_rs,
  output logic [1:0]  fwd_d_rt,
  output logic [1:0]  fwd_e_rs,
  output logic [1:0]  fwd_e_rt,
  output logic        fwd_m_rt,
`ifdef HAZARD_STALL_STATS_EN
  output logic [31:0] stall_cnt,
`endif
  output logic        md_busy
);

  localparam int CNT_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // Shadow pipeline: only what hazard detection needs from E, M and W
  logic [4:0]    r_e_rs, r_e_rt, r_e_a3;
  logic [1:0]    r_e_tnew;
  logic          r_e_md, r_e_md_div;
  logic [4:0]    r_m_rt, r_m_a3;
  logic [1:0]    r_m_tnew;
  logic [4:0]    r_w_a3;
  logic [CW-1:0] r_md_cnt;

  logic w_stall_rs, w_stall_rt, w_stall_md, w_md_busy;

  // A producer blocks a consumer only when its result is still further away than the use point
  assign w_stall_rs = (d_rs != 5'd0) && (d_tuse_rs != 2'd3) &&
                      (((r_e_a3 == d_rs) && (r_e_tnew > d_tuse_rs)) ||
                       ((r_m_a3 == d_rs) && (r_m_tnew > d_tuse_rs)));
  assign w_stall_rt = (d_rt != 5'd0) && (d_tuse_rt != 2'd3) &&
                      (((r_e_a3 == d_rt) && (r_e_tnew > d_tuse_rt)) ||
                       ((r_m_a3 == d_rt) && (r_m_tnew > d_tuse_rt)));

  // An MD op sitting in E has not loaded the counter yet, so it counts as busy too
  assign w_md_busy  = r_e_md || (r_md_cnt != '0);
  assign w_stall_md = d_md_use && w_md_busy;

  assign stall   = w_stall_rs || w_stall_rt || w_stall_md;
  assign md_busy = w_md_busy;

  // D-stage forwarding: youngest ready producer wins; $0 always reads the register file
  assign fwd_d_rs = (d_rs == 5'd0)                              ? 2'b00 :
                    ((r_e_a3 == d_rs) && (r_e_tnew == 2'd0))    ? 2'b01 :
                    ((r_m_a3 == d_rs) && (r_m_tnew == 2'd0))    ? 2'b10 :
                    (r_w_a3 == d_rs)                            ? 2'b11 : 2'b00;
  assign fwd_d_rt = (d_rt == 5'd0)                              ? 2'b00 :
                    ((r_e_a3 == d_rt) && (r_e_tnew == 2'd0))    ? 2'b01 :
                    ((r_m_a3 == d_rt) && (r_m_tnew == 2'd0))    ? 2'b10 :
                    (r_w_a3 == d_rt)                            ? 2'b11 : 2'b00;

  // E-stage forwarding into the ALU operands and store data
  assign fwd_e_rs = ((r_m_a3 == r_e_rs) && (r_m_a3 != 5'd0) && (r_m_tnew == 2'd0)) ? 2'b01 :
                    ((r_w_a3 == r_e_rs) && (r_w_a3 != 5'd0))                       ? 2'b10 : 2'b00;
  assign fwd_e_rt = ((r_m_a3 == r_e_rt) && (r_m_a3 != 5'd0) && (r_m_tnew == 2'd0)) ? 2'b01 :
                    ((r_w_a3 == r_e_rt) && (r_w_a3 != 5'd0))                       ? 2'b10 : 2'b00;

  // M-stage store data can still pick up a W-stage result
  assign fwd_m_rt = (r_w_a3 == r_m_rt) && (r_w_a3 != 5'd0);

  // Advance the shadow pipeline; a stall injects a bubble into E
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_e_rs     <= '0;
      r_e_rt     <= '0;
      r_e_a3     <= '0;
      r_e_tnew   <= '0;
      r_e_md     <= 1'b0;
      r_e_md_div <= 1'b0;
      r_m_rt     <= '0;
      r_m_a3     <= '0;
      r_m_tnew   <= '0;
      r_w_a3     <= '0;
    end else begin
      r_m_rt   <= r_e_rt;
      r_m_a3   <= r_e_a3;
      r_m_tnew <= (r_e_tnew == 2'd0) ? 2'd0 : r_e_tnew - 2'd1;
      r_w_a3   <= r_m_a3;
      if (stall) begin
        r_e_rs     <= '0;
        r_e_rt     <= '0;
        r_e_a3     <= '0;
        r_e_tnew   <= '0;
        r_e_md     <= 1'b0;
        r_e_md_div <= 1'b0;
      end else begin
        r_e_rs     <= d_rs;
        r_e_rt     <= d_rt;
        r_e_a3     <= d_a3;
        r_e_tnew   <= d_tnew;
        r_e_md     <= d_md_start;
        r_e_md_div <= d_md_div;
      end
    end
  end

  // MD busy window: load on the edge the op leaves E, then count down to idle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_md_cnt <= '0;
    end else if (r_e_md) begin
      r_md_cnt <= r_e_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - CW'(1);
    end
  end

`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] r_stall_cnt;

  // Count stalled cycles; wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  d_rs, d_rt, d_a3;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        d_md_start, d_md_div, d_md_use;
  logic        stall, fwd_m_rt, md_busy;
  logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];
  string       tag_q[$];
  logic [10:0] w_obs;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_a3       (d_a3),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .d_md_use   (d_md_use),
    .stall      (stall),
    .fwd_d_rs   (fwd_d_rs),
    .fwd_d_rt   (fwd_d_rt),
    .fwd_e_rs   (fwd_e_rs),
    .fwd_e_rt   (fwd_e_rt),
    .fwd_m_rt   (fwd_m_rt),
`ifdef HAZARD_STALL_STATS_EN
    .stall_cnt  (stall_cnt),
`endif
    .md_busy    (md_busy)
  );

  // {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy}
  assign w_obs = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tr, input logic [1:0] tt,
                       input logic [4:0] a3, input logic [1:0] tn,
                       input logic ms, input logic mdv, input logic mu);
    d_rs = rs; d_rt = rt; d_tuse_rs = tr; d_tuse_rt = tt;
    d_a3 = a3; d_tnew = tn; d_md_start = ms; d_md_div = mdv; d_md_use = mu;
  endtask

  // Expected outputs for the current D inputs are queued, then compared mid-cycle
  task automatic step(input string tag, input logic [10:0] exp_v);
    logic [10:0] e;
    string       t;
    exp_q.push_back(exp_v);
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (w_obs === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", t, w_obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    set_d(8, 9, 0, 0, 8, 2, 1, 1, 1);
    @(posedge clk);
    #1;
    step("reset_outputs", 11'b0_00_00_00_00_0_0);
`ifdef HAZARD_STALL_STATS_EN
    checks++;
    assert (stall_cnt === 32'd0) else begin
      errors++;
      $error("FAIL stall_cnt_reset observed=%0d expected=0", stall_cnt);
    end
`endif
    reset = 1'b1;

    // lw $8 then addu $9,$8,$8
    set_d(29, 8, 1, 3, 8, 2, 0, 0, 0); step("lw_issue",         11'b0_00_00_00_00_0_0);
    set_d(8, 8, 1, 1, 9, 1, 0, 0, 0);  step("load_use_stall",   11'b1_00_00_00_00_0_0);
                                        step("load_use_release", 11'b0_00_00_00_00_0_0);
    // addu $3 then beq $3,$0
    set_d(1, 2, 1, 1, 3, 1, 0, 0, 0);  step("fwd_e_from_w",     11'b0_00_00_10_10_0_0);
    set_d(3, 0, 0, 0, 0, 0, 0, 0, 0);  step("beq_stall",        11'b1_00_00_00_00_0_0);
                                        step("beq_fwd_m",        11'b0_10_00_00_00_0_0);
`ifdef HAZARD_STALL_STATS_EN
    checks++;
    assert (stall_cnt === 32'd2) else begin
      errors++;
      $error("FAIL stall_cnt_two observed=%0d expected=2", stall_cnt);
    end
`endif
    // jal then jr $31, then priority and store-data forwarding
    set_d(0, 0, 3, 3, 31, 0, 0, 0, 0); step("jal_issue",        11'b0_00_00_10_00_0_0);
    set_d(31, 0, 0, 3, 0, 0, 0, 0, 0); step("jr_fwd_e",         11'b0_01_00_00_00_0_0);
    set_d(0, 31, 3, 3, 31, 0, 0, 0, 0); step("lui_first",       11'b0_00_10_01_00_0_0);
    set_d(0, 31, 3, 3, 31, 0, 0, 0, 0); step("lui_second",      11'b0_00_01_00_10_0_0);
    set_d(31, 0, 0, 3, 0, 0, 0, 0, 0); step("e_over_m",         11'b0_01_00_00_01_0_0);
    set_d(0, 0, 3, 3, 0, 0, 0, 0, 0);  step("fwd_m_rt",         11'b0_00_00_01_00_1_0);
                                        step("drain",            11'b0_00_00_00_00_0_0);

    // Writers of $0 in E/M/W while D reads $0
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("zero_reg", 11'b0_00_00_00_00_0_0);

    // div then mflo: DIV_CYCLES+1 stalled cycles
    set_d(4, 5, 1, 1, 0, 0, 1, 1, 1);  step("div_issue",        11'b0_00_00_00_00_0_0);
    set_d(0, 0, 3, 3, 6, 1, 0, 0, 1);
    for (int i = 0; i < 11; i++) step("div_busy", 11'b1_00_00_00_00_0_1);
    step("div_done", 11'b0_00_00_00_00_0_0);

    // mult then mfhi: MULT_CYCLES+1 stalled cycles
    set_d(4, 5, 1, 1, 0, 0, 1, 0, 1);  step("mult_issue",       11'b0_00_00_00_00_0_0);
    set_d(0, 0, 3, 3, 7, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) step("mult_busy", 11'b1_00_00_00_00_0_1);
    step("mult_done", 11'b0_00_00_00_00_0_0);

    // Reset in the middle of a divide
    set_d(4, 5, 1, 1, 0, 0, 1, 1, 1);  step("div2_issue",       11'b0_00_00_00_00_0_0);
    set_d(0, 0, 3, 3, 0, 0, 0, 0, 0);  step("div2_busy_e",      11'b0_00_00_00_00_0_1);
    reset = 1'b0;                       step("div2_busy_cnt",    11'b0_00_00_00_00_0_1);
    reset = 1'b1;
    set_d(0, 0, 3, 3, 6, 1, 0, 0, 1);  step("reset_mid_div",    11'b0_00_00_00_00_0_0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
